// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer access arbiter.
package fb_pkg;

  localparam int unsigned FB_H_ACTIVE = 640;
  localparam int unsigned FB_V_ACTIVE = 480;
  localparam int unsigned FB_ADDR_W   = 19;
  localparam int unsigned FB_DATA_W   = 8;
  localparam int unsigned FB_DEPTH    = FB_H_ACTIVE * FB_V_ACTIVE;

  typedef logic [FB_DATA_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    S_BLANK = 2'd0,
    S_DISP  = 2'd1,
    S_WRITE = 2'd2
  } fb_state_e;

endpackage

// File: rtl/fb_rd_addr_gen.sv
// Display read address counter: linear scan, cleared in vertical blanking,
// wraps to 0 after the last framebuffer location.
module fb_rd_addr_gen
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_W   = FB_ADDR_W,
  parameter int unsigned DEPTH    = FB_DEPTH,
  parameter int unsigned V_ACTIVE = FB_V_ACTIVE
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [9:0]        v_cnt_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] rd_addr_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] r_addr;
  logic              w_vblank;

  assign w_vblank  = (v_cnt_i >= 10'(V_ACTIVE));
  assign rd_addr_o = r_addr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr <= '0;
    end else if (w_vblank) begin
      r_addr <= '0;
    end else if (inc_i) begin
      r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
    end
  end

endmodule

// File: rtl/fb_access_arbiter.sv
// Arbitrates one single-port framebuffer RAM between VGA display reads and host writes.
// Optional one-entry host write buffer: define FB_WR_BUF_EN.
module fb_access_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned H_ACTIVE = FB_H_ACTIVE,
  parameter int unsigned V_ACTIVE = FB_V_ACTIVE,
  parameter int unsigned ADDR_W   = FB_ADDR_W,
  parameter int unsigned DATA_W   = FB_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [9:0]        h_cnt_i,
  input  logic [9:0]        v_cnt_i,
  input  logic              d_ena_i,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ack_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] pix_o,
  output logic              pix_valid_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  fb_state_e         r_state;
  fb_state_e         w_state_d;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_wr_in_range;
  logic              w_wr_pending;
  logic [ADDR_W-1:0] w_cmt_addr;
  logic [DATA_W-1:0] w_cmt_data;
  logic              w_cmt_we;

  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_wr_ack;
  logic              r_dena_1;
  logic              r_dena_2;
  logic              r_pix_valid;
  logic [DATA_W-1:0] r_pix;

  // Line position is implied by d_ena_i; the horizontal count is not needed.
  logic w_unused_h;
  assign w_unused_h = ^h_cnt_i;

  assign w_wr_in_range = (wr_addr_i <= LAST_ADDR);

  fb_rd_addr_gen #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (H_ACTIVE * V_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_rd_addr_gen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .v_cnt_i   (v_cnt_i),
    .inc_i     (d_ena_i),
    .rd_addr_o (w_rd_addr)
  );

`ifdef FB_WR_BUF_EN
  logic              r_buf_full;
  logic [ADDR_W-1:0] r_buf_addr;
  logic [DATA_W-1:0] r_buf_data;

  assign w_wr_pending = r_buf_full;
  assign w_cmt_addr   = r_buf_addr;
  assign w_cmt_data   = r_buf_data;
  assign w_cmt_we     = 1'b1;

  // Out-of-range requests are acked but never occupy the buffer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_buf_full <= 1'b0;
      r_buf_addr <= '0;
      r_buf_data <= '0;
      r_wr_ack   <= 1'b0;
    end else begin
      r_wr_ack <= 1'b0;
      if (w_state_d == S_WRITE) begin
        r_buf_full <= 1'b0;
      end
      if (wr_req_i && !r_buf_full && !r_wr_ack) begin
        r_wr_ack   <= 1'b1;
        r_buf_full <= w_wr_in_range;
        r_buf_addr <= wr_addr_i;
        r_buf_data <= wr_data_i;
      end
    end
  end
`else
  // The requester still holds wr_req_i during the ack cycle; mask it there.
  assign w_wr_pending = wr_req_i && (r_state != S_WRITE);
  assign w_cmt_addr   = wr_addr_i;
  assign w_cmt_data   = wr_data_i;
  assign w_cmt_we     = w_wr_in_range;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ack <= 1'b0;
    end else begin
      r_wr_ack <= (w_state_d == S_WRITE);
    end
  end
`endif

  always_comb begin
    w_state_d = S_BLANK;
    if (d_ena_i) begin
      w_state_d = S_DISP;
    end else if (w_wr_pending) begin
      w_state_d = S_WRITE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_BLANK;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      r_state  <= w_state_d;
      r_mem_we <= 1'b0;
      case (w_state_d)
        S_DISP: begin
          r_mem_addr <= w_rd_addr;
        end
        S_WRITE: begin
          r_mem_addr  <= w_cmt_addr;
          r_mem_wdata <= w_cmt_data;
          r_mem_we    <= w_cmt_we;
        end
        default: ;
      endcase
    end
  end

  // d_ena_i -> address (n+1) -> RAM data (n+2) -> pixel register (n+3)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_dena_1    <= 1'b0;
      r_dena_2    <= 1'b0;
      r_pix_valid <= 1'b0;
      r_pix       <= '0;
    end else begin
      r_dena_1    <= d_ena_i;
      r_dena_2    <= r_dena_1;
      r_pix_valid <= r_dena_2;
      r_pix       <= r_dena_2 ? mem_rdata_i : '0;
    end
  end

  assign wr_ack_o    = r_wr_ack;
  assign mem_addr_o  = r_mem_addr;
  assign mem_we_o    = r_mem_we;
  assign mem_wdata_o = r_mem_wdata;
  assign pix_o       = r_pix;
  assign pix_valid_o = r_pix_valid;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed bench for fb_access_arbiter with a compressed frame (one or two lines per frame).
module tb_fb_access_arbiter;
  import fb_pkg::*;

  localparam int H_TOT = 800;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        d_ena;
  logic        wr_req;
  logic [18:0] wr_addr;
  pixel_t      wr_data;
  logic        wr_ack;
  logic [18:0] mem_addr;
  logic        mem_we;
  pixel_t      mem_wdata;
  pixel_t      mem_rdata;
  pixel_t      pix;
  logic        pix_valid;

  pixel_t ram [0:FB_DEPTH-1];
  pixel_t img [0:2047];
  int     errors = 0;
  int     checks = 0;

  always #5 clk = ~clk;

  fb_access_arbiter u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .h_cnt_i     (h_cnt),
    .v_cnt_i     (v_cnt),
    .d_ena_i     (d_ena),
    .wr_req_i    (wr_req),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .wr_ack_o    (wr_ack),
    .mem_addr_o  (mem_addr),
    .mem_we_o    (mem_we),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .pix_o       (pix),
    .pix_valid_o (pix_valid)
  );

  // Single-port synchronous RAM, read-before-write.
  always @(posedge clk) begin
    if (int'(mem_addr) < FB_DEPTH) begin
      mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One video line: 640 active + 160 blank cycles. Optional host write from wr_c,
  // held until the expected ack cycle. ack_c/we_c = -1 means never.
  task automatic run_line(input int v, input int base, input int wr_c, input logic [18:0] wa,
                          input pixel_t wd, input int ack_c, input int we_c);
    bit req_done = 1'b0;
    for (int c = 0; c < H_TOT; c++) begin
      h_cnt = 10'(c);
      v_cnt = 10'(v);
      d_ena = (c < 640);
      if (wr_c >= 0 && c >= wr_c && !req_done) begin
        wr_req  = 1'b1;
        wr_addr = wa;
        wr_data = wd;
      end else begin
        wr_req = 1'b0;
      end
      tick();
      if (c < 640) check("rd_addr", 32'(mem_addr), 32'(base + c));
      check("mem_we", 32'(mem_we), 32'(c == we_c));
      check("wr_ack", 32'(wr_ack), 32'(c == ack_c));
      if (c == we_c) begin
        check("wr_addr_out", 32'(mem_addr), 32'(wa));
        check("wr_data_out", 32'(mem_wdata), 32'(wd));
      end
      if (c >= 2 && c < 642) begin
        check("pix_valid", 32'(pix_valid), 32'd1);
        check("pix", 32'(pix), 32'(img[base + c - 2]));
      end else begin
        check("pix_valid_idle", 32'(pix_valid), 32'd0);
        check("pix_idle", 32'(pix), 32'd0);
      end
      if (c == ack_c) req_done = 1'b1;
    end
    wr_req = 1'b0;
    if (we_c >= 0 && int'(wa) < 2048) img[wa] = wd;
  endtask

  task automatic run_vblank(input int n);
    for (int i = 0; i < n; i++) begin
      h_cnt = 10'(i);
      v_cnt = 10'd480;
      d_ena = 1'b0;
      tick();
      check("vb_we", 32'(mem_we), 32'd0);
      check("vb_valid", 32'(pix_valid), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < FB_DEPTH; i++) ram[i] = pixel_t'(i);
    for (int i = 0; i < 2048; i++) img[i] = pixel_t'(i);
    rst     = 1'b1;
    h_cnt   = 10'd300;
    v_cnt   = 10'd200;
    d_ena   = 1'b1;
    wr_req  = 1'b0;
    wr_addr = '0;
    wr_data = '0;

    // Reset held two cycles mid-frame with active video on the inputs.
    tick();
    tick();
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_ack", 32'(wr_ack), 32'd0);
    check("rst_pix", 32'(pix), 32'd0);
    check("rst_valid", 32'(pix_valid), 32'd0);
    rst   = 1'b0;
    d_ena = 1'b0;

    // First active line after reset starts fetching at address 0.
    run_line(200, 0, -1, '0, '0, -1, -1);
    run_vblank(10);

    // Write during active video waits for blanking.
`ifdef FB_WR_BUF_EN
    run_line(0, 0, 100, 19'd5, 8'hAA, 100, 640);
`else
    run_line(0, 0, 100, 19'd5, 8'hAA, 640, 640);
`endif
    // Out-of-range write in horizontal blanking: acked, never written.
    run_line(1, 640, 700, 19'd307200, 8'h55, 700, -1);
    run_vblank(10);

`ifdef FB_WR_BUF_EN
    // Back-to-back requests: second one waits for the first to commit.
    begin
      bit first_done = 1'b0;
      bit second_done = 1'b0;
      for (int c = 0; c < H_TOT; c++) begin
        h_cnt = 10'(c);
        v_cnt = 10'd2;
        d_ena = (c < 640);
        wr_req = 1'b0;
        if (c >= 100 && !first_done) begin
          wr_req = 1'b1; wr_addr = 19'd20; wr_data = 8'h11;
        end else if (first_done && !second_done) begin
          wr_req = 1'b1; wr_addr = 19'd21; wr_data = 8'h22;
        end
        tick();
        check("bb_ack", 32'(wr_ack), 32'(c == 100 || c == 641));
        check("bb_we", 32'(mem_we), 32'(c == 640 || c == 642));
        if (c == 640) check("bb_addr1", 32'(mem_addr), 32'd20);
        if (c == 642) check("bb_addr2", 32'(mem_addr), 32'd21);
        if (c == 100) first_done = 1'b1;
        if (c == 641) second_done = 1'b1;
      end
      wr_req  = 1'b0;
      img[20] = 8'h11;
      img[21] = 8'h22;
    end
    run_vblank(10);
`endif

    // New frame: address restarts at 0 and the committed write is visible.
    run_line(0, 0, -1, '0, '0, -1, -1);

    // Reset during a write commit cycle.
    v_cnt   = 10'd480;
    d_ena   = 1'b0;
    wr_req  = 1'b1;
    wr_addr = 19'd10;
    wr_data = 8'h33;
    tick();
`ifdef FB_WR_BUF_EN
    check("mw_ack", 32'(wr_ack), 32'd1);
    wr_req = 1'b0;
    tick();
`else
    check("mw_ack", 32'(wr_ack), 32'd1);
`endif
    check("mw_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    check("mw_rst_we", 32'(mem_we), 32'd0);
    check("mw_rst_ack", 32'(wr_ack), 32'd0);
    wr_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_we", 32'(mem_we), 32'd0);
    check("post_rst_ack", 32'(wr_ack), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_access_arbiter.md
Name: fb_access_arbiter

Overview:
Shares one single-port synchronous framebuffer RAM between two agents. The VGA display fetch is driven by the h/v pixel counters and d_ena from the VGA timing FSM; the host write port is used by the image-processing side. Display reads have absolute priority during active video, and host writes are committed only in blanking. The block sits between the VGA timing FSM/counters, the framebuffer RAM and the pixel output register.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
ADDR_W, 19, framebuffer address width (must hold H_ACTIVE*V_ACTIVE-1)
DATA_W, 8, pixel width

Ports:
clk_i  in  1  pixel clock
rst_i  in  1  asynchronous active-high reset
h_cnt_i  in  10  horizontal pixel counter
v_cnt_i  in  10  vertical line counter
d_ena_i  in  1  active-video flag from the timing FSM
wr_req_i  in  1  host write request; held until acked
wr_addr_i  in  ADDR_W  host write address
wr_data_i  in  DATA_W  host write data
wr_ack_o  out  1  one-cycle pulse: write accepted
mem_addr_o  out  ADDR_W  RAM address (registered)
mem_we_o  out  1  RAM write enable (registered)
mem_wdata_o  out  DATA_W  RAM write data (registered)
mem_rdata_i  in  DATA_W  RAM read data, valid one cycle after address
pix_o  out  DATA_W  display pixel
pix_valid_o  out  1  pix_o is an active-video pixel

Behaviour:
- Reset (asynchronous, active-high): every output is 0, the read address counter is 0, the FSM is in S_BLANK, and any pending write is discarded.
- FSM states:
  - S_BLANK: no RAM activity.
  - S_DISP: a read is issued this cycle.
  - S_WRITE: one commit cycle.
- Transitions, evaluated every cycle:
  - If d_ena_i=1, go to S_DISP.
  - Else if a write is pending, go to S_WRITE.
  - Otherwise, go to S_BLANK.
  - S_WRITE always lasts exactly one cycle before re-evaluation.
- Display read:
  - In S_DISP, mem_addr_o takes rd_addr and rd_addr increments by 1.
  - rd_addr clears to 0 whenever v_cnt_i >= V_ACTIVE (vertical blanking).
  - No multiplier is used.
  - rd_addr never exceeds H_ACTIVE*V_ACTIVE-1. If it would, it saturates and a further increment wraps to 0.
- Display latency: d_ena_i sampled high at cycle n gives mem_addr_o at n+1, mem_rdata_i at n+2, and pix_o registered at n+3. pix_valid_o is d_ena_i delayed by 3 cycles. While pix_valid_o=0, pix_o=0.
- Write commit (S_WRITE):
  - mem_we_o=1 for one cycle with the pending address and data.
  - Outside S_WRITE, mem_we_o=0.
- Write handshake: wr_addr_i and wr_data_i must be stable while wr_req_i=1. wr_ack_o pulses for 1 cycle. Requests are not queued beyond the rules below.
- Out-of-range write (wr_addr_i >= H_ACTIVE*V_ACTIVE): acked as normal, mem_we_o stays 0, data dropped.
- Simultaneous d_ena_i rise and pending write: display wins and the write waits for the next blanking interval. Horizontal blanking occurs every line, so worst-case write wait is one active line (H_ACTIVE cycles plus pipeline).
- Reset asserted mid-write: mem_we_o drops immediately and no ack is issued; the requester must re-issue.

Optional Feature:
FB_WR_BUF_EN
- Enabled: a one-entry write buffer. wr_ack_o is issued the cycle after wr_req_i when the buffer is empty, in any state including active video. The buffered entry commits at the next S_WRITE. While the buffer is full, new requests wait (no ack).
- Disabled: no buffer. wr_ack_o is asserted in the same cycle as the S_WRITE commit.

Decomposition:
- Package fb_pkg: the state enum (S_BLANK, S_DISP, S_WRITE), the FB_DEPTH = H_ACTIVE*V_ACTIVE constant, and the pixel_t typedef.
- One natural sub-module, fb_rd_addr_gen: the read address counter with vertical-blank clear and wrap.
- Arbitration FSM and output registers stay in the top module.

Test Plan:
- Reset: hold rst_i=1 for 2 cycles mid-frame, then release → all outputs 0, first active pixel reads address 0.
- Line fetch: first active line, RAM preloaded with data=addr[7:0] → pix_o runs 0,1,2,…,255,0,… starting 3 cycles after d_ena_i; pix_valid_o is high for 640 cycles.
- Write deferred: wr_req_i at h_cnt_i=100 of an active line, addr=5, data=0xAA → mem_we_o only at the first blanking cycle. Unbuffered: wr_ack_o in the same cycle. Next frame: pix_o=0xAA at pixel 5.
- Out-of-range: write to addr 307200 → wr_ack_o pulses, mem_we_o stays 0.
- Frame wrap: at v_cnt_i=480 → rd_addr clears, and the next frame's first mem_addr_o=0.
- FB_WR_BUF_EN: two back-to-back requests during active video → first acked in 1 cycle, second acked only after the first commits in blanking; both land in RAM in order.
